// File: rtl/rfphoenix_mc_wb_queue_pkg.sv
// rfphoenix_mc_wb_queue_pkg: shared types for the multicycle ALU writeback queue
//   MCWBQ_DEPTH    : queue depth, also sizes the issue stage's outstanding-op credit
//   tid_t          : thread tag
//   pipeline_reg_t : completed ALU result with decode fields and thread tag
package rfphoenix_mc_wb_queue_pkg;
   localparam int MCWBQ_DEPTH = 4;
   typedef logic [2:0] tid_t;
   typedef struct packed {
      logic [31:0] res;
      logic [5:0]  rd;
      logic [7:0]  op;
      tid_t        tid;
   } pipeline_reg_t;
endpackage

// File: rtl/rfphoenix_mc_wb_queue_if.sv
// rfphoenix_mc_wb_queue_if: ALU-side push, flush, and arbiter-side pop bundle
//   master : ALU/issue/arbiter side, drives i, i_valid, flush, flush_tid, o_ready
//   slave  : queue side, drives o, o_valid, full, afull, count, ovf
interface rfphoenix_mc_wb_queue_if
   import rfphoenix_mc_wb_queue_pkg::*;
#(
   parameter int DEPTH = MCWBQ_DEPTH
);
   pipeline_reg_t                  i;
   logic                           i_valid;
   logic                           flush;
   tid_t                           flush_tid;
   pipeline_reg_t                  o;
   logic                           o_valid;
   logic                           o_ready;
   logic                           full;
   logic                           afull;
   logic [$clog2(DEPTH+1)-1:0]     count;
   logic                           ovf;
   modport master (output i, i_valid, flush, flush_tid, o_ready,
                   input  o, o_valid, full, afull, count, ovf);
   modport slave  (input  i, i_valid, flush, flush_tid, o_ready,
                   output o, o_valid, full, afull, count, ovf);
endinterface

// File: rtl/rfphoenix_mc_wb_queue.sv
// rfphoenix_mc_wb_queue: in-order result buffer between the multicycle ALU and writeback, with per-thread flush
//   clk, rst : clock, asynchronous active-high reset
//   q        : slave side of rfphoenix_mc_wb_queue_if (push/flush in, head/flags out)
module rfphoenix_mc_wb_queue
   import rfphoenix_mc_wb_queue_pkg::*;
#(
   parameter int DEPTH = MCWBQ_DEPTH,
   parameter int AFULL = DEPTH - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   rfphoenix_mc_wb_queue_if.slave  q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   pipeline_reg_t   mem [DEPTH];
   logic [DEPTH-1:0] live;
   logic [PW-1:0]   wp, rp;
   logic [CW-1:0]   cnt;
   logic            ovf_r;
   logic            nonempty, head_ok, pop, push, kill_in, is_full;
   always_comb begin
      nonempty = cnt != '0;
      head_ok  = nonempty & live[rp];
      // dead heads retire on their own so a flushed thread never stalls the queue
      pop      = (head_ok & q.o_ready) | (nonempty & ~live[rp]);
      is_full  = cnt == CW'(DEPTH);
      push     = q.i_valid & (~is_full | pop);
      kill_in  = q.flush & (q.i.tid == q.flush_tid);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
         live  <= '0;
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         ovf_r <= 1'b0;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            if (q.flush && mem[k].tid == q.flush_tid) live[k] <= 1'b0;
         // the write slot's live bit is set last so it wins over a flush of the old occupant
         if (push) begin
            mem[wp]  <= q.i;
            live[wp] <= ~kill_in;
            wp       <= wp + PW'(1);
         end else if (q.i_valid) begin
            ovf_r <= 1'b1;
         end
         if (pop) rp <= rp + PW'(1);
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end
   assign q.o       = mem[rp];
   assign q.o_valid = head_ok;
   assign q.full    = is_full;
   assign q.afull   = cnt >= CW'(AFULL);
   assign q.count   = cnt;
   assign q.ovf     = ovf_r;
endmodule

// File: tb/tb_rfphoenix_mc_wb_queue.sv
// tb_rfphoenix_mc_wb_queue: randomized self-checking bench against a queue-of-entries reference model
module tb_rfphoenix_mc_wb_queue;
   import rfphoenix_mc_wb_queue_pkg::*;
   localparam int DEPTH = 4;
   typedef struct { pipeline_reg_t d; bit live; } mentry_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   mentry_t m[$];
   bit      m_ovf = 1'b0;
   rfphoenix_mc_wb_queue_if #(.DEPTH(DEPTH)) q();
   rfphoenix_mc_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(q));
   always #5 clk = ~clk;
   function automatic pipeline_reg_t mk(input logic [31:0] res, input tid_t t);
      pipeline_reg_t p;
      p.res = res;
      p.rd  = 6'($urandom);
      p.op  = 8'($urandom);
      p.tid = t;
      return p;
   endfunction
   function automatic bit m_ov();
      return m.size() != 0 && m[0].live;
   endfunction
   function automatic logic [6:0] dut_st();
      return {q.o_valid, q.count, q.full, q.afull, q.ovf};
   endfunction
   function automatic logic [6:0] mdl_st();
      return {m_ov(), 3'(m.size()), m.size() == DEPTH, m.size() >= DEPTH - 1, m_ovf};
   endfunction
   // one clock of stimulus; the model advances from the pre-edge state using the queue rules
   task automatic drive(input bit iv, input pipeline_reg_t d, input bit rdy, input bit fl, input tid_t ft);
      bit pop, push;
      @(negedge clk);
      q.i = d; q.i_valid = iv; q.o_ready = rdy; q.flush = fl; q.flush_tid = ft;
      pop  = (m_ov() && rdy) || (m.size() != 0 && !m[0].live);
      push = iv && (m.size() < DEPTH || pop);
      if (fl) foreach (m[k]) if (m[k].d.tid == ft) m[k].live = 1'b0;
      if (pop) void'(m.pop_front());
      if (push) m.push_back(mentry_t'{d, !(fl && d.tid == ft)});
      else if (iv) m_ovf = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic idle(input bit rdy);
      drive(1'b0, '0, rdy, 1'b0, '0);
   endtask
   task automatic do_reset();
      q.i_valid = 1'b0; q.flush = 1'b0; q.o_ready = 1'b0; q.i = '0; q.flush_tid = '0;
      rst = 1'b1;
      m.delete(); m_ovf = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      n_vec++;
      if (dut_st() !== 7'b0) begin n_err++; $display("FAIL reset_status got %b want %b", dut_st(), 7'b0); end
      n_vec++;
      if (q.o !== '0) begin n_err++; $display("FAIL reset_o got %h want 0", q.o); end
   endtask
   task automatic test_single();
      do_reset();
      drive(1'b1, mk(32'h1234, 3'd2), 1'b1, 1'b0, '0);
      n_vec++;
      if ({q.o_valid, q.count, q.ovf} !== {1'b1, 3'd1, 1'b0} || q.o.res !== 32'h1234) begin
         n_err++; $display("FAIL single_head got v=%b c=%0d res=%h want v=1 c=1 res=1234", q.o_valid, q.count, q.o.res);
      end
      idle(1'b1);
      n_vec++;
      if (dut_st() !== mdl_st() || q.count !== 3'd0) begin n_err++; $display("FAIL single_drain got %b want %b", dut_st(), mdl_st()); end
   endtask
   task automatic test_fill();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, mk(32'hA000 + k, 3'(k)), 1'b0, 1'b0, '0);
         n_vec++;
         if (dut_st() !== mdl_st()) begin n_err++; $display("FAIL fill_%0d got %b want %b", k, dut_st(), mdl_st()); end
      end
      n_vec++;
      if ({q.full, q.count, q.ovf} !== {1'b1, 3'd4, 1'b1}) begin n_err++; $display("FAIL fill_flags got full=%b c=%0d ovf=%b want 1 4 1", q.full, q.count, q.ovf); end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (q.o_valid !== 1'b1 || q.o.res !== 32'hA000 + k) begin n_err++; $display("FAIL drain_%0d got v=%b res=%h want v=1 res=%h", k, q.o_valid, q.o.res, 32'hA000 + k); end
         idle(1'b1);
      end
      n_vec++;
      if (dut_st() !== mdl_st()) begin n_err++; $display("FAIL fill_end got %b want %b", dut_st(), mdl_st()); end
   endtask
   task automatic test_full_pop();
      do_reset();
      for (int k = 0; k < 4; k++) drive(1'b1, mk(32'hB000 + k, '0), 1'b0, 1'b0, '0);
      drive(1'b1, mk(32'hBEEF, 3'd1), 1'b1, 1'b0, '0);
      n_vec++;
      if ({q.count, q.ovf, q.full} !== {3'd4, 1'b0, 1'b1}) begin n_err++; $display("FAIL fullpop_flags got c=%0d ovf=%b full=%b want 4 0 1", q.count, q.ovf, q.full); end
      for (int k = 0; k < 4; k++) begin
         n_vec++;
         if (q.o_valid !== 1'b1 || q.o !== m[0].d) begin n_err++; $display("FAIL fullpop_%0d got %h want %h", k, q.o, m[0].d); end
         idle(1'b1);
      end
      n_vec++;
      if (m.size() != 0 || q.count !== 3'd0) begin n_err++; $display("FAIL fullpop_end got c=%0d want 0", q.count); end
   endtask
   task automatic test_flush();
      tid_t tids[4] = '{3'd1, 3'd3, 3'd1, 3'd2};
      tid_t seen[$];
      do_reset();
      foreach (tids[k]) drive(1'b1, mk(32'hC000 + k, tids[k]), 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b0, 1'b1, 3'd1);
      for (int c = 0; c < 6; c++) begin
         if (q.o_valid === 1'b1) seen.push_back(q.o.tid);
         idle(1'b1);
         n_vec++;
         if (dut_st() !== mdl_st()) begin n_err++; $display("FAIL flush_cyc%0d got %b want %b", c, dut_st(), mdl_st()); end
      end
      n_vec++;
      if (seen.size() != 2 || seen[0] !== 3'd3 || seen[1] !== 3'd2) begin n_err++; $display("FAIL flush_order got %p want 3,2", seen); end
   endtask
   task automatic test_flush_push();
      do_reset();
      drive(1'b1, mk(32'hD005, 3'd5), 1'b1, 1'b1, 3'd5);
      for (int c = 0; c < 3; c++) begin
         n_vec++;
         if (q.o_valid !== 1'b0 || dut_st() !== mdl_st()) begin n_err++; $display("FAIL flushpush_%0d got %b want %b", c, dut_st(), mdl_st()); end
         idle(1'b1);
      end
   endtask
   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 3; k++) drive(1'b1, mk(32'hE000 + k, 3'(k)), 1'b0, 1'b0, '0);
      #2;
      q.i_valid = 1'b0; q.flush = 1'b0;
      rst = 1'b1;
      m.delete(); m_ovf = 1'b0;
      #1;
      n_vec++;
      if (dut_st() !== 7'b0) begin n_err++; $display("FAIL async_reset got %b want %b", dut_st(), 7'b0); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         idle(1'b1);
         n_vec++;
         if (q.o_valid !== 1'b0 || dut_st() !== mdl_st() || q.o !== '0) begin n_err++; $display("FAIL post_reset_%0d got %b o=%h want %b o=0", c, dut_st(), q.o, mdl_st()); end
      end
   endtask
   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, mk($urandom, 3'($urandom_range(0, 3))), $urandom_range(0, 2) != 0,
               $urandom_range(0, 9) == 0, 3'($urandom_range(0, 3)));
         n_vec++;
         if (dut_st() !== mdl_st()) begin n_err++; $display("FAIL rand_st_%0d got %b want %b", c, dut_st(), mdl_st()); end
         if (m_ov()) begin
            n_vec++;
            if (q.o !== m[0].d) begin n_err++; $display("FAIL rand_o_%0d got %h want %h", c, q.o, m[0].d); end
         end
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_flush();
      test_flush_push();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
